// File: rtl/adder_arbiter.sv
// adder_arbiter: one WIDTH-bit adder shared by two requesters.
// A round-robin pointer breaks ties. Each operation takes three cycles:
// grant and latch, add, respond.
//
// state | meaning
// IDLE  | waiting for a request; operands are latched on the grant edge
// ADD   | latched operands are summed into s/ovf
// RESP  | the one-cycle ack for the granted requester is produced

module adder_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] s,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_gnt;        // requester currently being served
    logic             r_last;       // requester granted most recently
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_s;
    logic             r_ovf;
    logic             r_ack0;
    logic             r_ack1;

    logic             w_grant_valid;
    logic             w_grant_id;
    logic [WIDTH:0]   w_sum;

    // Next-state logic and arbitration; a tie goes to the requester not served last
    always_comb begin
        w_next_state  = r_state;
        w_grant_valid = 1'b0;
        w_grant_id    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0 && req1) begin
                    w_grant_valid = 1'b1;
                    w_grant_id    = ~r_last;
                end else if (req0) begin
                    w_grant_valid = 1'b1;
                    w_grant_id    = 1'b0;
                end else if (req1) begin
                    w_grant_valid = 1'b1;
                    w_grant_id    = 1'b1;
                end
                if (w_grant_valid) begin
                    w_next_state = ADD;
                end
            end
            ADD:     w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign w_sum = {1'b0, r_op_a} + {1'b0, r_op_b};

    // State register, operand latch, result register and ack pulses.
    // r_last resets to 1 so that the first tie after reset goes to requester 0.
    // The ack is registered on the RESP edge, so it stays high for the cycle after RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_s     <= '0;
            r_ovf   <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            if (r_state == IDLE && w_grant_valid) begin
                r_gnt  <= w_grant_id;
                r_last <= w_grant_id;
                r_op_a <= w_grant_id ? a1 : a0;
                r_op_b <= w_grant_id ? b1 : b0;
            end
            if (r_state == ADD) begin
                {r_ovf, r_s} <= w_sum;
            end
            if (r_state == RESP) begin
                r_ack0 <= ~r_gnt;
                r_ack1 <= r_gnt;
            end
        end
    end

    assign ack0 = r_ack0;
    assign ack1 = r_ack1;
    assign s    = r_s;
    assign ovf  = r_ovf;
    assign busy = (r_state != IDLE);

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving operand/result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port req0, input, 1 bit, requester 0 add request.
REQ-005 The block SHALL have ports a0 and b0, input, WIDTH bits each, requester 0 operands.
REQ-006 The block SHALL have port req1, input, 1 bit, requester 1 add request.
REQ-007 The block SHALL have ports a1 and b1, input, WIDTH bits each, requester 1 operands.
REQ-008 The block SHALL have ports ack0 and ack1, output, 1 bit each, one-cycle completion strobe per requester.
REQ-009 The block SHALL have port s, output, WIDTH bits, registered sum.
REQ-010 The block SHALL have port ovf, output, 1 bit, registered carry-out of the sum.
REQ-011 The block SHALL have port busy, output, 1 bit, high whenever state is not IDLE.

Function
REQ-012 The block SHALL share one WIDTH-bit adder between two requesters with FSM states IDLE, ADD, RESP.
REQ-013 In IDLE with no request, the FSM SHALL stay in IDLE and all outputs SHALL hold.
REQ-014 In IDLE with exactly one reqN high at a rising edge, the block SHALL grant N, latch aN/bN into internal operand registers, and move to ADD.
REQ-015 In IDLE with req0 and req1 both high, the block SHALL grant the requester not served last (round-robin pointer); after reset the pointer SHALL favour requester 0.
REQ-016 The pointer SHALL update to the granted requester only on a grant.
REQ-017 In ADD, the block SHALL register {ovf,s} = opA + opB as a (WIDTH+1)-bit unsigned sum (s = sum mod 2^WIDTH, ovf = carry-out) and move to RESP.
REQ-018 In RESP, the block SHALL assert ackN for the granted requester only, for exactly one cycle, with the other ack low, then return to IDLE.
REQ-019 Latency SHALL be: req sampled at edge T -> ackN high from edge T+2 to T+3; s/ovf valid from edge T+2.
REQ-020 s and ovf SHALL hold their values until the next ADD-to-RESP transition.
REQ-021 Requesters SHALL hold reqN and operands stable until ackN; operands changing after the grant edge SHALL NOT affect the result.
REQ-022 reqN still high in IDLE after its ack SHALL be treated as a new request (re-arbitrated).
REQ-023 reqN deasserted after grant SHALL NOT abort the operation; the ack SHALL still be issued.
REQ-024 Maximum throughput SHALL be one operation per 3 cycles.
REQ-025 Requests arriving while busy SHALL be ignored until the FSM returns to IDLE.

Reset
REQ-026 With rst high at a rising edge, regardless of state, the block SHALL go to IDLE and drive s=0, ovf=0, ack0=0, ack1=0, busy=0, set the pointer to favour requester 0, and clear the operand registers.
REQ-027 Reset mid-operation (ADD or RESP) SHALL abort the operation with no ack issued.
REQ-028 Requests held through reset release SHALL be arbitrated fresh at the first edge with rst low.

Verification
REQ-029 req0=1, a0=70, b0=1 from IDLE -> ack0 pulse 2 cycles later, {ovf,s}=71, ack1=0 throughout.
REQ-030 req1=1, a1=10, b1=16 -> ack1 pulse, s=26, ovf=0; a0=200, b0=100 on req0 -> s=44, ovf=1.
REQ-031 req0 and req1 both held high after reset -> acks alternate ack0, ack1, ack0, ack1 at 3-cycle spacing, each carrying its own requester's sum.
REQ-032 rst pulsed while in ADD -> next cycle s=0, ovf=0, busy=0, no ack; held req0 is then served with the correct sum.
REQ-033 a0=0, b0=0 -> s=0, ovf=0; req0 dropped one cycle after grant -> ack0 still pulses with the correct result.
REQ-034 req1 pulsed while busy serving requester 0 and dropped before IDLE -> no ack1, no second operation.
